// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 hex keypad scanner: row strobe, column debounce, one key code per press.
// Define KEYPAD_OPERAND_EN to build the 32-bit operand shift register and clr handling.
module keypad_scan #(
  parameter int SCAN_DIV     = 260000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [3:0]  col,
  input  logic        clr,
  output logic [3:0]  row,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [31:0] operand
);

  localparam int         CW      = (SCAN_DIV < 1) ? 1 : $clog2(SCAN_DIV + 1);
  localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_HELD
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic            tick;
  logic [3:0]      col_meta, col_sync;
  logic [1:0]      row_idx, row_idx_n;
  logic [1:0]      col_lat, col_lat_n;
  logic [3:0]      deb, deb_n;
  logic [3:0]      rel, rel_n;
  logic            one_low;
  logic            all_high;
  logic [1:0]      col_idx;
  logic            accept;
  logic [3:0]      code;

  // Columns are pulled up and asynchronous; idle value of the synchronizer is all-high.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= col;
      col_sync <= col_meta;
    end
  end

  assign tick = (cnt == CW'(SCAN_DIV));

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Only a single low column is a key; ghosting patterns decode as no key.
  always_comb begin
    one_low = 1'b0;
    col_idx = 2'd0;
    case (col_sync)
      4'b1110: begin one_low = 1'b1; col_idx = 2'd0; end
      4'b1101: begin one_low = 1'b1; col_idx = 2'd1; end
      4'b1011: begin one_low = 1'b1; col_idx = 2'd2; end
      4'b0111: begin one_low = 1'b1; col_idx = 2'd3; end
      default: begin one_low = 1'b0; col_idx = 2'd0; end
    endcase
  end

  assign all_high = &col_sync;
  assign code     = {row_idx, col_idx};

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state   <= S_SCAN;
      row_idx <= 2'd0;
      col_lat <= 2'd0;
      deb     <= 4'd0;
      rel     <= 4'd0;
    end else begin
      state   <= state_n;
      row_idx <= row_idx_n;
      col_lat <= col_lat_n;
      deb     <= deb_n;
      rel     <= rel_n;
    end
  end

  always_comb begin
    state_n   = state;
    row_idx_n = row_idx;
    col_lat_n = col_lat;
    deb_n     = deb;
    rel_n     = rel;
    accept    = 1'b0;
    if (tick) begin
      case (state)
        S_SCAN: begin
          if (one_low) begin
            col_lat_n = col_idx;
            if (DEB_MAX <= 4'd1) begin
              accept  = 1'b1;
              deb_n   = 4'd0;
              state_n = S_HELD;
            end else begin
              deb_n   = 4'd1;
              state_n = S_DEBOUNCE;
            end
          end else begin
            row_idx_n = row_idx + 2'd1;
          end
        end
        S_DEBOUNCE: begin
          if (one_low && (col_idx == col_lat)) begin
            if (deb + 4'd1 >= DEB_MAX) begin
              accept  = 1'b1;
              deb_n   = 4'd0;
              state_n = S_HELD;
            end else begin
              deb_n = deb + 4'd1;
            end
          end else begin
            deb_n     = 4'd0;
            row_idx_n = row_idx + 2'd1;
            state_n   = S_SCAN;
          end
        end
        S_HELD: begin
          if (all_high) begin
            if (rel + 4'd1 >= DEB_MAX) begin
              rel_n     = 4'd0;
              row_idx_n = row_idx + 2'd1;
              state_n   = S_SCAN;
            end else begin
              rel_n = rel + 4'd1;
            end
          end else begin
            rel_n = 4'd0;
          end
        end
        default: begin
          state_n = S_SCAN;
          deb_n   = 4'd0;
          rel_n   = 4'd0;
        end
      endcase
    end
  end

  assign row = ~(4'b0001 << row_idx);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      key_valid <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= code;
      end
    end
  end

`ifdef KEYPAD_OPERAND_EN
  // A clear coinciding with an accept leaves only the new nibble.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      operand <= 32'h0;
    end else if (accept) begin
      operand <= {(clr ? 28'd0 : operand[27:0]), code};
    end else if (clr) begin
      operand <= 32'h0;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign operand    = 32'h0;
`endif

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix-keypad scanner and operand entry block: the input-side counterpart of the seven-segment display scanner. It strobes the four rows of a 4x4 hex keypad one at a time, with the same one-hot-low rotation and scan rate as the digit anodes. It senses the active-low columns, debounces each press, and emits one hex key code per press. The code is shifted into a 32-bit operand register that drives the ALU A/B operand path in place of the fixed switch-selected constants.

## Interface

- SCAN_DIV, 260000: tick period is SCAN_DIV+1 clocks; rows advance and columns are sampled only on ticks.
- DEBOUNCE_CNT, 4: number of consecutive stable ticks needed to accept a press and to accept a release; range 1..15.

- clock  in  1  system clock, all logic on its rising edge.
- rst  in  1  reset; one clock; asynchronous, active-low.
- col  in  4  column sense, active-low (pulled up); asynchronous, passed through a 2-flop synchronizer before use.
- clr  in  1  synchronous operand clear, active-high.
- row  out  4  row strobe, one-hot-low.
- key_valid  out  1  one-clock pulse per accepted press.
- key_code  out  4  hex code of last accepted key; held until the next press.
- operand  out  32  entered value; new nibble enters at [3:0].

## Operation

- Tick generator: counter 0..SCAN_DIV; tick asserted the cycle count == SCAN_DIV; counter wraps to 0.
- Row rotation (SCAN state only): 1110 -> 1101 -> 1011 -> 0111 -> 1110. Row index r = 0..3 in that order. Row is frozen in all other states.
- Column index c = position of the single low bit of synchronized col; c = 0 for col[0].
- Key code = 4*r + c, giving 0x0..0xF.
- Valid press: exactly one col bit low. Zero bits or more than one bit low (ghosting) is treated as no key.
- State machine, evaluated on ticks only:
  - SCAN:
    - Valid press: latch c, set deb = 1, go DEBOUNCE. If DEBOUNCE_CNT == 1, accept immediately.
    - Otherwise: advance row.
  - DEBOUNCE:
    - Same single column low: deb++. When deb reaches DEBOUNCE_CNT, accept the press and go HELD.
    - Anything else: go SCAN, deb = 0, advance row.
  - HELD:
    - All col high: rel++. When rel reaches DEBOUNCE_CNT, go SCAN with rel = 0 and advance row.
    - Any col low: rel = 0.
- Accept: the cycle after the accepting tick:
  - key_valid = 1 for that one cycle;
  - key_code = code;
  - operand = {operand[27:0], code}.
- Holding a key yields exactly one key_valid; there is no auto-repeat.
- clr:
  - Alone: operand = 0 next cycle.
  - In the same cycle as an accept: operand = {28'd0, code}; the clear applies first, then the shift.
  - clr does not affect the FSM, key_code, or key_valid.
- Operand wraps silently: the ninth nibble pushes the oldest nibble out of [31:28].

## Timing

- Reset values: row = 4'b1110, key_valid = 0, key_code = 4'h0, operand = 32'h0. FSM = SCAN; tick counter, deb, rel and the synchronizer are all cleared (synchronizer flops reset to 1).
- Row changes on the clock after a tick. Each row is therefore held SCAN_DIV+1 cycles, which is well beyond the 2-cycle synchronizer latency.
- Press latency: a col change reaches the FSM 2 clocks later. key_valid fires 1 clock after the DEBOUNCE_CNT-th stable tick, where the detection tick counts as the first.
- Minimum time between two accepted presses: 2*DEBOUNCE_CNT ticks.
- Reset asserted mid-DEBOUNCE or mid-HELD aborts the press; no key_valid is emitted afterwards.

## Configuration

- KEYPAD_OPERAND_EN:
  - Defined: the 32-bit operand shift register and clr handling are built as described.
  - Undefined: operand is tied to 32'h0 and clr is ignored. Scanning, debouncing, key_code and key_valid are unchanged.

## Test plan

All scenarios use SCAN_DIV = 3, DEBOUNCE_CNT = 2, with KEYPAD_OPERAND_EN defined unless noted.

- Reset: drive rst low mid-run -> row = 1110, operand = 0, key_valid = 0 immediately. After release, row rotates every 4 clocks.
- Single press: hold col = 1011 while row = 1101 -> exactly one key_valid pulse, key_code = 4'h6. A long hold gives no second pulse; after release, scanning resumes.
- Entry: press keys 1, 2, 3, 4 in turn -> operand = 32'h00001234. Nine presses of 0xF -> operand = 32'hFFFFFFFF.
- Bounce and ghost: col low for only one tick, or col = 1001 -> no key_valid, and the row resumes rotating.
- clr: clr pulse -> operand = 0. clr in the same cycle as an accept of key 0xA -> operand = 32'h0000000A.
- Reset during DEBOUNCE -> no key_valid is emitted. With KEYPAD_OPERAND_EN undefined, presses still pulse key_valid while operand stays 0.
